// File: rtl/operand_fetch_pkg.sv
// Shared widths and types for the operand fetch stage and its scoreboard.
// XBUS is the datapath width, R_MSB the register index MSB, R_COUNT the register count.
package operand_fetch_pkg;

  localparam int XBUS    = 32;
  localparam int R_MSB   = 4;
  localparam int R_COUNT = 2 ** (R_MSB + 1);

  typedef logic [R_MSB:0]  reg_idx_t;
  typedef logic [XBUS-1:0] xword_t;

  typedef struct packed {
    xword_t   op1;
    xword_t   op2;
    reg_idx_t rd;
    logic     rd_we;
    xword_t   uop;
  } issue_t;

  // x0 is never tracked, so a write to it creates no pending state.
  function automatic logic tracks_rd(input logic we, input reg_idx_t rd);
    return we && (rd != '0);
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy bits for pending writes; set on issue, cleared on writeback or flush.
// Set wins over clear on the same bit, and register 0 never reads busy.
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R_MSB:0] set_addr,
  input  logic           set_en,
  input  logic [R_MSB:0] clr_addr,
  input  logic           clr_en,
  input  logic           flush,
  input  logic [R_MSB:0] rs1_addr,
  input  logic [R_MSB:0] rs2_addr,
  input  logic [R_MSB:0] rd_addr,
  output logic           rs1_busy,
  output logic           rs2_busy,
  output logic           rd_busy
);

  logic [R_COUNT-1:0] busy_q;
  logic [R_COUNT-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (tracks_rd(clr_en, clr_addr)) busy_d[clr_addr] = 1'b0;
    if (tracks_rd(set_en, set_addr)) busy_d[set_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign rd_busy  = busy_q[rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads operands, stalls on RAW/WAW via the scoreboard, and holds one output entry.
// Define OPFETCH_BYPASS_EN to forward same-cycle writeback data into busy sources.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [R_MSB:0]  in_rs1,
  input  logic [R_MSB:0]  in_rs2,
  input  logic [R_MSB:0]  in_rd,
  input  logic            in_rd_we,
  input  logic [XBUS-1:0] in_uop,
  output logic [R_MSB:0]  rf_rd_addr1,
  output logic [R_MSB:0]  rf_rd_addr2,
  input  logic [XBUS-1:0] rf_rd_data1,
  input  logic [XBUS-1:0] rf_rd_data2,
  input  logic            wb_valid,
  input  logic [R_MSB:0]  wb_addr,
  input  logic [XBUS-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XBUS-1:0] out_op1,
  output logic [XBUS-1:0] out_op2,
  output logic [R_MSB:0]  out_rd,
  output logic            out_rd_we,
  output logic [XBUS-1:0] out_uop
);

`ifdef OPFETCH_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  logic   rs1_busy, rs2_busy, rd_busy;
  logic   rs1_hit, rs2_hit;
  logic   hazard, accept;
  xword_t op1_sel, op2_sel;
  issue_t out_q, out_d;
  logic   out_valid_q, out_valid_d;

  operand_fetch_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_addr (in_rd),
    .set_en   (accept && in_rd_we),
    .clr_addr (wb_addr),
    .clr_en   (wb_valid),
    .flush    (flush),
    .rs1_addr (in_rs1),
    .rs2_addr (in_rs2),
    .rd_addr  (in_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  assign rf_rd_addr1 = in_rs1;
  assign rf_rd_addr2 = in_rs2;

  // Without bypass the hit terms are constant zero and the mux folds away.
  assign rs1_hit = BYPASS_EN && rs1_busy && wb_valid && (wb_addr == in_rs1);
  assign rs2_hit = BYPASS_EN && rs2_busy && wb_valid && (wb_addr == in_rs2);
  assign op1_sel = rs1_hit ? wb_data : rf_rd_data1;
  assign op2_sel = rs2_hit ? wb_data : rf_rd_data2;

  assign hazard   = (rs1_busy && !rs1_hit) || (rs2_busy && !rs2_hit)
                  || (tracks_rd(in_rd_we, in_rd) && rd_busy);
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_d       = '{op1: op1_sel, op2: op2_sel, rd: in_rd, rd_we: in_rd_we, uop: in_uop};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_q.op1;
  assign out_op2   = out_q.op2;
  assign out_rd    = out_q.rd;
  assign out_rd_we = out_q.rd_we;
  assign out_uop   = out_q.uop;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed plus randomized checks of operand_fetch against a behavioural scoreboard/regfile model.
// Build with OPFETCH_BYPASS_EN defined to exercise the bypass variant.
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic [31:0] in_uop;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2, out_uop;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  int total = 0;
  int bad   = 0;

  // Environment register file plus reference model of the stage.
  logic [31:0] rf_mem [32];
  bit          m_busy [32];
  bit          m_out_valid;
  logic [31:0] m_op1, m_op2, m_uop;
  logic [4:0]  m_rd;
  logic        m_rd_we;

  assign rf_rd_data1 = rf_mem[rf_rd_addr1];
  assign rf_rd_data2 = rf_mem[rf_rd_addr2];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_uop(in_uop),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_uop(out_uop)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_out_valid = 1'b0;
    m_op1 = '0; m_op2 = '0; m_uop = '0; m_rd = '0; m_rd_we = 1'b0;
  endtask

  function automatic bit srcBypass(input logic [4:0] s, input logic wbv, input logic [4:0] wba);
    return BYP && s != 0 && m_busy[s] && wbv && wba == s;
  endfunction

  // One clock cycle: drive inputs, check handshake, advance model across the edge, check outputs.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we, input logic [31:0] uop,
                               input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                               input logic fl, input logic ordy);
    bit blk1, blk2, waw, exp_ready, acc;
    logic [31:0] op1, op2;
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we; in_uop = uop;
    wb_valid = wbv; wb_addr = wba; wb_data = wbd; flush = fl; out_ready = ordy;
    #1;
    blk1 = m_busy[rs1] && !srcBypass(rs1, wbv, wba);
    blk2 = m_busy[rs2] && !srcBypass(rs2, wbv, wba);
    waw  = we && rd != 0 && m_busy[rd];
    exp_ready = !fl && !blk1 && !blk2 && !waw && (!m_out_valid || ordy);
    acc = v && exp_ready;
    op1 = srcBypass(rs1, wbv, wba) ? wbd : rf_mem[rs1];
    op2 = srcBypass(rs2, wbv, wba) ? wbd : rf_mem[rs2];
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("rf_addr1", 32'(rf_rd_addr1), 32'(rs1));
    checkOutput("rf_addr2", 32'(rf_rd_addr2), 32'(rs2));
    @(posedge clk);
    #1;
    if (fl) begin
      m_out_valid = 1'b0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wbv && wba != 0) m_busy[wba] = 1'b0;
      if (acc && we && rd != 0) m_busy[rd] = 1'b1;
      if (acc) begin
        m_out_valid = 1'b1;
        m_op1 = op1; m_op2 = op2; m_rd = rd; m_rd_we = we; m_uop = uop;
      end else if (ordy) begin
        m_out_valid = 1'b0;
      end
    end
    if (wbv && wba != 0) rf_mem[wba] = wbd;
    checkOutput("out_valid", 32'(out_valid), 32'(m_out_valid));
    if (m_out_valid) begin
      checkOutput("out_op1", out_op1, m_op1);
      checkOutput("out_op2", out_op2, m_op2);
      checkOutput("out_rd", 32'(out_rd), 32'(m_rd));
      checkOutput("out_rd_we", 32'(out_rd_we), 32'(m_rd_we));
      checkOutput("out_uop", out_uop, m_uop);
    end
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [31:0] uop, input logic ordy);
    applyStimulus(1'b1, rs1, rs2, rd, we, uop, 1'b0, 5'd0, 32'd0, 1'b0, ordy);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
    modelReset();
    rst_n = 1'b0;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_uop = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_op1", out_op1, 32'd0);
    checkOutput("rst_out_op2", out_op2, 32'd0);
    checkOutput("rst_out_rd", 32'(out_rd), 32'd0);
    checkOutput("rst_out_rd_we", 32'(out_rd_we), 32'd0);
    checkOutput("rst_out_uop", out_uop, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // x0 sources, rd=1 becomes busy
    issue(5'd0, 5'd0, 5'd1, 1'b1, 32'hA1, 1'b1);
    checkOutput("x0_op1", out_op1, 32'd0);
    checkOutput("x0_op2", out_op2, 32'd0);
    // RAW on x1 until writeback of 123
    issue(5'd1, 5'd0, 5'd2, 1'b0, 32'hA2, 1'b1);
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, 32'hA2, 1'b1, 5'd1, 32'd123, 1'b0, 1'b1);
    issue(5'd1, 5'd0, 5'd2, 1'b0, 32'hA2, 1'b1);
    checkOutput("raw_valid", 32'(out_valid), 32'd1);
    checkOutput("raw_op1", out_op1, 32'd123);

    // Back-pressure hold then drain with same-cycle accept
    for (int i = 0; i < 5; i++) issue(5'd0, 5'd1, 5'd0, 1'b0, 32'hB0, 1'b0);
    checkOutput("hold_uop", out_uop, 32'hA2);
    issue(5'd0, 5'd1, 5'd0, 1'b0, 32'hB0, 1'b1);
    checkOutput("drain_uop", out_uop, 32'hB0);

    // WAW on x3
    issue(5'd0, 5'd0, 5'd3, 1'b1, 32'hC1, 1'b1);
    issue(5'd0, 5'd0, 5'd3, 1'b1, 32'hC2, 1'b1);
    issue(5'd0, 5'd0, 5'd3, 1'b1, 32'hC2, 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'hC2, 1'b1, 5'd3, 32'd99, 1'b0, 1'b1);
    issue(5'd0, 5'd0, 5'd3, 1'b1, 32'hC2, 1'b1);
    checkOutput("waw_uop", out_uop, 32'hC2);
    issue(5'd3, 5'd0, 5'd0, 1'b0, 32'hC3, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd3, 32'd77, 1'b0, 1'b1);

    // rd=0 never tracked, writeback to x0 ignored
    issue(5'd0, 5'd0, 5'd0, 1'b1, 32'hD1, 1'b1);
    issue(5'd0, 5'd0, 5'd4, 1'b0, 32'hD2, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 5'd0, 32'd69, 1'b0, 1'b1);
    issue(5'd0, 5'd0, 5'd4, 1'b0, 32'hD3, 1'b1);
    checkOutput("x0_wb_op1", out_op1, 32'd0);

    // Flush with x5 busy and output valid
    issue(5'd0, 5'd0, 5'd5, 1'b1, 32'hE1, 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'hE2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    issue(5'd5, 5'd0, 5'd0, 1'b0, 32'hE3, 1'b1);
    checkOutput("flush_accept_uop", out_uop, 32'hE3);

    // Async reset while stalled
    issue(5'd0, 5'd0, 5'd6, 1'b1, 32'hF1, 1'b0);
    issue(5'd6, 5'd0, 5'd0, 1'b0, 32'hF2, 1'b0);
    in_valid = 1'b0; in_rs1 = 5'd6; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue-side stage directly upstream of `Registers`. It accepts decoded instructions over a valid/ready handshake, drives the register file's two read ports, and tracks pending destination writes in a per-register busy scoreboard. It stalls on RAW/WAW hazards and presents both operands plus the destination to the execute stage in a one-entry output register. The writeback port that writes `Registers` also clears the scoreboard.

## Interface
Parameters:
- None. Widths come from `XBUS` (data) and `R_MSB` (register index) in `defs.v`.

Ports:
- `clk` in 1: clock; all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage accepts this cycle.
- `in_rs1`, `in_rs2` in `R_MSB+1`: source register indices.
- `in_rd` in `R_MSB+1`: destination index.
- `in_rd_we` in 1: instruction writes `in_rd`.
- `in_uop` in `XBUS`: opaque payload, passed through unchanged.
- `rf_rd_addr1`, `rf_rd_addr2` out `R_MSB+1`: to `Registers` read ports; combinational copies of `in_rs1`/`in_rs2`.
- `rf_rd_data1`, `rf_rd_data2` in `XBUS`: combinational read data from `Registers`.
- `wb_valid` in 1: writeback this cycle (same signal as `Registers.wr_en`).
- `wb_addr` in `R_MSB+1`, `wb_data` in `XBUS`: writeback target and value.
- `flush` in 1: synchronous kill.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_op1`, `out_op2` out `XBUS`; `out_rd` out `R_MSB+1`; `out_rd_we` out 1; `out_uop` out `XBUS`.

## Operation
- Scoreboard: `busy` holds one bit per register. Bit 0 is hard-wired to 0.
- Source `s` (rs1 or rs2) is blocked when `busy[s]` is set, excluding bypass hits (see Configuration).
- WAW hazard: `in_rd_we` is set, `in_rd != 0`, and `busy[in_rd]` is set.
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`. `in_ready` is independent of `in_valid`.
- On accept (`in_valid && in_ready`):
  - The output register loads the operands, `in_rd`, `in_rd_we` and `in_uop`, and `out_valid <= 1`.
  - If `in_rd_we` is set and `in_rd != 0`, then `busy[in_rd] <= 1`.
- `out_valid && out_ready` with no accept that cycle: `out_valid <= 0`.
- `out_valid && !out_ready`: all `out_*` hold stable.
- `wb_valid` with `wb_addr != 0`: `busy[wb_addr] <= 0`.
- Set and clear of the same bit in the same cycle: set wins. This only occurs on a protocol error, because a WAW stall prevents it otherwise.
- A writeback to x0 is ignored.
- `flush`:
  - Effective next edge: `out_valid <= 0` and all busy bits cleared.
  - Nothing is accepted in the flush cycle.
  - Downstream is flushed in the same cycle and never writes back killed instructions.

## Timing
- Reset (async assert, sync-to-clock deassert by the integrator): `out_valid=0`, all `out_*=0`, `busy=0`. `in_ready` reads 1 when `flush=0` and there is no hazard.
- Latency: accept at edge N gives `out_valid=1` with operands after edge N. Throughput is one instruction per cycle.
- Register-file reads are combinational within the accept cycle. A writeback at edge N is visible through `rf_rd_data*` from N+1.
- Without bypass: an instruction whose source's writeback occurs at edge N is accepted no earlier than the cycle after N. It reads the new value from the register file.
- Reset mid-stall discards the held output and the entire scoreboard.

## Configuration
- `OPFETCH_BYPASS_EN` defined:
  - A busy source whose `wb_valid && wb_addr == s` holds this cycle is not blocked.
  - Its operand is taken from `wb_data` instead of `rf_rd_data*`.
  - Bypass saves one cycle per RAW dependency.
- `OPFETCH_BYPASS_EN` undefined:
  - No bypass mux.
  - A busy source always stalls until the cycle after its writeback.
- A WAW hazard stalls in both builds.

## Structure
- `defs.v` gains the constant `R_COUNT` (`2**(R_MSB+1)`) for scoreboard sizing. It already provides `XBUS` and `R_MSB`.
- Sub-module `Scoreboard`:
  - Inputs: set port (`addr`, `en`), clear port (`addr`, `en`), `flush`, `clk`, `rst_n`.
  - Outputs: two read lookups plus one rd lookup.
- `operand_fetch` holds the handshake, bypass mux and output register.

## Test plan
- Reset, then issue rs1=0, rs2=0, rd=1, `in_rd_we=1` -> `out_valid` the next cycle with op1=op2=0; `busy[1]=1`.
- With x1 busy, issue rs1=1 -> `in_ready=0` until writeback x1=123.
  - Bypass build: accepted in the wb cycle with op1=123.
  - No-bypass build: accepted one cycle later with op1=123.
- Hold `out_ready=0` with the output valid -> `in_ready=0`, and `out_*` are unchanged for 5 cycles. Raising `out_ready` drains, and the next instruction is accepted in the same cycle.
- Issue rd=3 `in_rd_we`, then rd=3 `in_rd_we` again -> the second stalls (WAW) until wb x3=99, then `busy[3]=1` again.
- Issue rd=0 with `in_rd_we=1`, then rs1=0 -> no stall, op1=0. wb x0=69 leaves op1=0.
- With x5 busy and `out_valid=1`, assert `flush` -> next cycle `out_valid=0` and an instruction with rs1=5 is accepted immediately.
